// File: rtl/multilane_shift_engine_if.sv
// Bundle of the data and status signals of multilane_shift_engine.
// The master side (the user of the engine) drives the controls and data in;
// the slave side (the engine itself) drives the shifted data and status.
//   en, mode       free-running operation select
//   sin            LANES-bit serial data in
//   pin            W-bit parallel load data
//   start          begin a framed transfer
//   msb_first      direction of a framed transfer
//   sout           LANES bits most recently shifted out
//   pout           current register contents
//   busy, done     framed transfer status
interface multilane_shift_engine_if #(
   parameter int W     = 8,
   parameter int LANES = 1
);
   logic             en;
   logic [2:0]       mode;
   logic [LANES-1:0] sin;
   logic [W-1:0]     pin;
   logic             start;
   logic             msb_first;
   logic [LANES-1:0] sout;
   logic [W-1:0]     pout;
   logic             busy;
   logic             done;

   modport master (
      output en, mode, sin, pin, start, msb_first,
      input  sout, pout, busy, done
   );

   modport slave (
      input  en, mode, sin, pin, start, msb_first,
      output sout, pout, busy, done
   );
endinterface

// File: rtl/multilane_shift_engine.sv
// Universal shift register moving LANES bits per shift, with free-running
// modes (hold/load/shl/shr/rotl/rotr/asr/clear) and a framed mode that
// serialises a W-bit word over K = W/LANES edges while capturing sin.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any frame without done
//   bus   slave side of multilane_shift_engine_if (see that file)
module multilane_shift_engine #(
   parameter int W     = 8,
   parameter int LANES = 1
) (
   input logic                  clk,
   input logic                  rst,
   multilane_shift_engine_if.slave bus
);

   localparam int K  = W / LANES;
   localparam int CW = $clog2(K + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           next_state;
   logic [W-1:0]     shreg;
   logic [LANES-1:0] sout_q;
   logic             done_q;
   logic             dir_msb;
   logic [CW-1:0]    cnt;
   logic             busy_c;
   logic             last_chunk;

   // Candidate next register values; written with shifts rather than part
   // selects so they stay legal even when W equals LANES.
   logic [W-1:0]     shl_val;
   logic [W-1:0]     shr_val;
   logic [W-1:0]     rotl_val;
   logic [W-1:0]     rotr_val;
   logic [W-1:0]     asr_val;

   assign shl_val  = (shreg << LANES) | W'(bus.sin);
   assign shr_val  = (shreg >> LANES) | (W'(bus.sin) << (W - LANES));
   assign rotl_val = (shreg << LANES) | (shreg >> (W - LANES));
   assign rotr_val = (shreg >> LANES) | (shreg << (W - LANES));
   assign asr_val  = W'($signed(shreg) >>> LANES);

   assign last_chunk = (cnt == CW'(1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: a frame lasts exactly K shift edges after the load edge
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = SHIFT;
         SHIFT:   if (last_chunk) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Moore outputs
   always_comb begin
      busy_c = 1'b0;
      if (state == SHIFT) busy_c = 1'b1;
   end

   // Datapath: start beats en/mode while idle; everything but the frame
   // shift is ignored while a frame is in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg   <= '0;
         sout_q  <= '0;
         done_q  <= 1'b0;
         dir_msb <= 1'b0;
         cnt     <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == SHIFT) begin
            if (dir_msb) begin
               shreg  <= shl_val;
               sout_q <= shreg[W-1 -: LANES];
            end else begin
               shreg  <= shr_val;
               sout_q <= shreg[LANES-1:0];
            end
            cnt <= cnt - CW'(1);
            if (last_chunk) done_q <= 1'b1;
         end else if (bus.start) begin
            shreg   <= bus.pin;
            dir_msb <= bus.msb_first;
            cnt     <= CW'(K);
         end else if (bus.en) begin
            case (bus.mode)
               3'b000: ;
               3'b001: shreg <= bus.pin;
               3'b010: begin
                  shreg  <= shl_val;
                  sout_q <= shreg[W-1 -: LANES];
               end
               3'b011: begin
                  shreg  <= shr_val;
                  sout_q <= shreg[LANES-1:0];
               end
               3'b100: begin
                  shreg  <= rotl_val;
                  sout_q <= '0;
               end
               3'b101: begin
                  shreg  <= rotr_val;
                  sout_q <= '0;
               end
               3'b110: begin
                  shreg  <= asr_val;
                  sout_q <= shreg[LANES-1:0];
               end
               default: begin
                  shreg  <= '0;
                  sout_q <= '0;
               end
            endcase
         end
      end
   end

   assign bus.pout = shreg;
   assign bus.sout = sout_q;
   assign bus.busy = busy_c;
   assign bus.done = done_q;

endmodule

// File: tb/tb_multilane_shift_engine.sv
module tb_multilane_shift_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Two engines side by side: one lane and two lanes, both 8 bits wide
   multilane_shift_engine_if #(.W(8), .LANES(1)) bus1 ();
   multilane_shift_engine_if #(.W(8), .LANES(2)) bus2 ();

   multilane_shift_engine #(.W(8), .LANES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   multilane_shift_engine #(.W(8), .LANES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   // Behavioural view of one engine: the word as an integer and a count of
   // chunks still to move in the current frame
   typedef struct {
      int v;
      int sout;
      bit busy;
      bit done;
      int remaining;
      bit msb;
   } mstate_t;

   mstate_t m1, m2;
   int q1[$];
   int q2[$];
   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // One clock edge of the specified behaviour for an 8-bit engine with L lanes
   function automatic mstate_t model_step(mstate_t s, int L, bit r, bit en, int mode,
                                          int sin, int pin, bit start, bit msb);
      mstate_t n;
      int lm;
      lm = (1 << L) - 1;
      n = s;
      n.done = 1'b0;
      if (r) begin
         n.v = 0; n.sout = 0; n.busy = 0; n.done = 0; n.remaining = 0; n.msb = 0;
         return n;
      end
      if (s.busy) begin
         if (s.msb) begin
            n.sout = (s.v >> (8 - L)) & lm;
            n.v    = ((s.v << L) | sin) & 255;
         end else begin
            n.sout = s.v & lm;
            n.v    = (s.v >> L) | (sin << (8 - L));
         end
         n.remaining = s.remaining - 1;
         if (n.remaining == 0) begin
            n.busy = 1'b0;
            n.done = 1'b1;
         end
      end else if (start) begin
         n.v = pin; n.msb = msb; n.remaining = 8 / L; n.busy = 1'b1;
      end else if (en) begin
         case (mode)
            1: n.v = pin;
            2: begin n.sout = (s.v >> (8 - L)) & lm; n.v = ((s.v << L) | sin) & 255; end
            3: begin n.sout = s.v & lm; n.v = (s.v >> L) | (sin << (8 - L)); end
            4: begin n.sout = 0; n.v = ((s.v << L) | (s.v >> (8 - L))) & 255; end
            5: begin n.sout = 0; n.v = (s.v >> L) | ((s.v & lm) << (8 - L)); end
            6: begin
               n.sout = s.v & lm;
               n.v = (s.v >> L) | (((s.v >> 7) & 1) != 0 ? (lm << (8 - L)) : 0);
            end
            7: begin n.sout = 0; n.v = 0; end
            default: ;
         endcase
      end
      return n;
   endfunction

   function automatic int pack(int v, int so, bit b, bit d);
      return (v << 16) | (so << 8) | (int'(b) << 1) | int'(d);
   endfunction

   // Drive one cycle of inputs to both engines, advance the model on the
   // edge and queue what each engine should then show
   task automatic applyStimulus(bit r, bit en, int mode, int pin, bit start, bit msb,
                                int sin1, int sin2);
      rst            = r;
      bus1.en        = en;     bus2.en        = en;
      bus1.mode      = 3'(mode); bus2.mode    = 3'(mode);
      bus1.pin       = 8'(pin); bus2.pin      = 8'(pin);
      bus1.start     = start;  bus2.start     = start;
      bus1.msb_first = msb;    bus2.msb_first = msb;
      bus1.sin       = 1'(sin1);
      bus2.sin       = 2'(sin2);
      @(posedge clk);
      m1 = model_step(m1, 1, r, en, mode, sin1 & 1, pin & 255, start, msb);
      m2 = model_step(m2, 2, r, en, mode, sin2 & 3, pin & 255, start, msb);
      q1.push_back(pack(m1.v, m1.sout, m1.busy, m1.done));
      q2.push_back(pack(m2.v, m2.sout, m2.busy, m2.done));
      #1;
   endtask

   // Directed check against a hand-derived constant
   task automatic checkOutput(string name, int actual, int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: every cycle each engine presents a new state, so one
   // queued expectation is retired per engine per falling edge
   initial begin
      int e, a;
      forever begin
         @(negedge clk);
         cycle++;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            a = pack(int'(bus1.pout), int'(bus1.sout), bus1.busy, bus1.done);
            total++;
            if (a !== e) begin
               bad++;
               $display("[TB] FAIL lane1 cycle %0d: got pout=%0h sout=%0h busy=%0b done=%0b, expected pout=%0h sout=%0h busy=%0b done=%0b",
                        cycle, a >> 16, (a >> 8) & 255, (a >> 1) & 1, a & 1,
                        e >> 16, (e >> 8) & 255, (e >> 1) & 1, e & 1);
            end
         end
         if (q2.size() > 0) begin
            e = q2.pop_front();
            a = pack(int'(bus2.pout), int'(bus2.sout), bus2.busy, bus2.done);
            total++;
            if (a !== e) begin
               bad++;
               $display("[TB] FAIL lane2 cycle %0d: got pout=%0h sout=%0h busy=%0b done=%0b, expected pout=%0h sout=%0h busy=%0b done=%0b",
                        cycle, a >> 16, (a >> 8) & 255, (a >> 1) & 1, a & 1,
                        e >> 16, (e >> 8) & 255, (e >> 1) & 1, e & 1);
            end
         end
      end
   end

   // Directed scenarios followed by a randomized soak
   initial begin
      logic [7:0] pat;
      m1 = '{default: 0};
      m2 = '{default: 0};
      pat = 8'hB4;

      // Reset out of power-up garbage
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset pout", int'(bus1.pout), 0);
      checkOutput("reset busy", int'(bus1.busy), 0);

      // Rotate left by one lane, then all the way round
      applyStimulus(0, 1, 1, 8'hA5, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
      checkOutput("rotl once", int'(bus1.pout), 8'h4B);
      for (int i = 0; i < 7; i++) applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
      checkOutput("rotl full", int'(bus1.pout), 8'hA5);

      // Reset with non-zero contents and sout
      applyStimulus(0, 1, 2, 0, 0, 0, 1, 3);
      applyStimulus(1, 1, 2, 0, 1, 1, 1, 3);
      checkOutput("reset2 pout", int'(bus1.pout), 0);
      checkOutput("reset2 sout", int'(bus1.sout), 0);
      checkOutput("reset2 done", int'(bus1.done), 0);

      // Arithmetic shift right, then shift left
      applyStimulus(0, 1, 1, 8'h90, 0, 0, 0, 0);
      applyStimulus(0, 1, 6, 0, 0, 0, 0, 0);
      checkOutput("asr pout", int'(bus1.pout), 8'hC8);
      checkOutput("asr sout", int'(bus1.sout), 0);
      applyStimulus(0, 1, 2, 0, 0, 0, 1, 0);
      checkOutput("shl pout", int'(bus1.pout), 8'h91);
      checkOutput("shl sout", int'(bus1.sout), 1);

      // MSB-first frame with sin held high; en/mode=clear must be ignored
      applyStimulus(0, 0, 0, 8'hB4, 1, 1, 1, 3);
      checkOutput("frame busy at load", int'(bus1.busy), 1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1, 7, 8'h00, 0, 0, 1, $urandom_range(0, 3));
         checkOutput("frame msb sout", int'(bus1.sout), int'(pat[7-i]));
         checkOutput("frame msb busy", int'(bus1.busy), (i < 7) ? 1 : 0);
      end
      checkOutput("frame msb done", int'(bus1.done), 1);
      checkOutput("frame msb pout", int'(bus1.pout), 8'hFF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("done single cycle", int'(bus1.done), 0);

      // LSB-first frame on the two-lane engine
      applyStimulus(0, 0, 0, 8'hB4, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 3));
         if (i < 4) checkOutput("frame lsb sout2", int'(bus2.sout), (8'hB4 >> (2 * i)) & 3);
         if (i == 3) checkOutput("frame lsb done2", int'(bus2.done), 1);
      end

      // Reset aborting a frame, then start beating a simultaneous clear
      applyStimulus(0, 0, 0, 8'h5A, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("abort busy", int'(bus1.busy), 0);
      checkOutput("abort pout", int'(bus1.pout), 0);
      checkOutput("abort done", int'(bus1.done), 0);
      applyStimulus(0, 1, 7, 8'h3C, 1, 0, 0, 0);
      checkOutput("start over clear", int'(bus1.pout), 8'h3C);
      checkOutput("start over clear busy", int'(bus1.busy), 1);

      // Back-to-back frames: restart in the cycle done is high
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);
      checkOutput("b2b done", int'(bus1.done), 1);
      applyStimulus(0, 0, 0, 8'hC3, 1, 1, 0, 1);
      checkOutput("b2b restart busy", int'(bus1.busy), 1);
      checkOutput("b2b restart pout", int'(bus1.pout), 8'hC3);

      // Randomized soak against the model
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 63) == 0),
                       ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 7),
                       $urandom_range(0, 255),
                       ($urandom_range(0, 7) == 0),
                       $urandom_range(0, 1),
                       $urandom_range(0, 1),
                       $urandom_range(0, 3));
      end

      // Let the monitor retire the last expectations
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
